// File: rtl/trainer_pkg.sv
// Shared encodings for the gate trainer: function select codes, JK actions
// and the per-lane combinational gate function.
package trainer_pkg;

  localparam logic [2:0] SEL_AND  = 3'd0;
  localparam logic [2:0] SEL_OR   = 3'd1;
  localparam logic [2:0] SEL_NAND = 3'd2;
  localparam logic [2:0] SEL_NOR  = 3'd3;
  localparam logic [2:0] SEL_XOR  = 3'd4;
  localparam logic [2:0] SEL_XNOR = 3'd5;
  localparam logic [2:0] SEL_NOTA = 3'd6;
  localparam logic [2:0] SEL_JK   = 3'd7;

  // JK action is the {J, K} pair taken from {op_a, op_b} of a lane.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_action_e;

  function automatic logic gate_fn(input logic [2:0] sel, input logic x, input logic z);
    logic r;
    r = 1'b0;
    case (sel)
      SEL_AND:  r = x & z;
      SEL_OR:   r = x | z;
      SEL_NAND: r = ~(x & z);
      SEL_NOR:  r = ~(x | z);
      SEL_XOR:  r = x ^ z;
      SEL_XNOR: r = ~(x ^ z);
      SEL_NOTA: r = ~x;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_trainer_stepper_step_gen.sv
// Step event source: rising-edge detect on the manual step level, or the
// auto-step period divider. The event is combinational and lasts one cycle.
module step_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             auto_en,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             step_evt
);

  logic             step_q;
  logic             armed;
  logic [DIV_W-1:0] cnt;
  logic             manual_evt;
  logic             auto_evt;

  // armed stays low after reset until step has been seen low, so a step held
  // through reset release cannot look like a fresh edge.
  assign manual_evt = !auto_en && armed && step && !step_q;
  assign auto_evt   = auto_en && (cnt >= div);
  assign step_evt   = manual_evt || auto_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
    end else begin
      step_q <= step;
      if (!step)
        armed <= 1'b1;
      if (!auto_en || auto_evt)
        cnt <= '0;
      else
        cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/gate_trainer_stepper.sv
// Multi-lane logic-gate / JK trainer. Operands come from ports or from an
// internal sweep counter advanced by step events.
module gate_trainer_stepper
  import trainer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             auto_en,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             sweep_done
);

  localparam int SW = 2 * WIDTH;

  logic             step_evt;
  logic [SW-1:0]    sweep;
  logic [WIDTH-1:0] app_a;
  logic [WIDTH-1:0] app_b;
  logic [WIDTH-1:0] jk;
  logic [WIDTH-1:0] jk_nxt;
  logic [WIDTH-1:0] fn;

  step_gen #(.DIV_W(DIV_W)) u_step_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .auto_en  (auto_en),
    .step     (step),
    .div      (div),
    .step_evt (step_evt)
  );

  assign app_a = auto_en ? sweep[WIDTH-1:0]  : a;
  assign app_b = auto_en ? sweep[SW-1:WIDTH] : b;

  always_comb begin
    fn = '0;
    for (int i = 0; i < WIDTH; i++)
      fn[i] = gate_fn(sel, op_a[i], op_b[i]);
  end

  // JK lanes act on the registered operands, and only on a step event in JK mode.
  always_comb begin
    jk_nxt = jk;
    if (sel == SEL_JK && step_evt) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (jk_action_e'({op_a[i], op_b[i]}))
          JK_CLEAR:  jk_nxt[i] = 1'b0;
          JK_SET:    jk_nxt[i] = 1'b1;
          JK_TOGGLE: jk_nxt[i] = ~jk[i];
          default:   jk_nxt[i] = jk[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      jk         <= '0;
      y          <= '0;
      sweep_done <= 1'b0;
    end else begin
      if (auto_en && step_evt)
        sweep <= sweep + SW'(1);
      op_a       <= app_a;
      op_b       <= app_b;
      jk         <= jk_nxt;
      y          <= (sel == SEL_JK) ? jk_nxt : fn;
      sweep_done <= auto_en && step_evt && (sweep == '1);
    end
  end

endmodule

// File: tb/tb_gate_trainer_stepper.sv
// Scoreboard bench for gate_trainer_stepper: a WIDTH=4 instance plus a
// WIDTH=2 instance sharing the same controls.
module tb_gate_trainer_stepper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       auto_en = 1'b0;
  logic       step = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic [2:0] sel = 3'd0;
  logic [7:0] div = 8'd0;

  logic [3:0] y, op_a, op_b;
  logic       sweep_done;
  logic [1:0] y2, op_a2, op_b2;
  logic       sweep_done2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] expv;

  gate_trainer_stepper #(.WIDTH(4), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .auto_en(auto_en),
    .step(step), .div(div), .y(y), .op_a(op_a), .op_b(op_b), .sweep_done(sweep_done)
  );

  gate_trainer_stepper #(.WIDTH(2), .DIV_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a[1:0]), .b(b[1:0]), .sel(sel), .auto_en(auto_en),
    .step(step), .div(div), .y(y2), .op_a(op_a2), .op_b(op_b2), .sweep_done(sweep_done2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] gate_model(input int s, input logic [3:0] x, input logic [3:0] z);
    case (s)
      0: return x & z;
      1: return x | z;
      2: return ~(x & z);
      3: return ~(x | z);
      4: return x ^ z;
      5: return ~(x ^ z);
      default: return ~x;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({y, op_a, op_b, sweep_done, y2, op_a2, op_b2, sweep_done2} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %h want 0",
               {y, op_a, op_b, sweep_done, y2, op_a2, op_b2, sweep_done2});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_gates();
    logic [3:0] pa, pb;
    auto_en = 1'b0;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pa = (p == 0) ? 4'b1100 : 4'b0011;
      pb = (p == 0) ? 4'b1010 : 4'b0101;
      for (int s = 0; s < 7; s++) begin
        a = pa; b = pb; sel = 3'(s);
        exp_q.push_back({28'd0, gate_model(s, pa, pb)});
        repeat (2) @(negedge clk);
        expv = exp_q.pop_front();
        tests++;
        if (y !== expv[3:0]) begin
          fails++;
          $display("[TB] FAIL gate sel=%0d a=%b b=%b: y=%b want %b", s, pa, pb, y, expv[3:0]);
        end
      end
    end
  endtask

  task automatic test_auto_walk();
    int nd;
    auto_en = 1'b0; sel = 3'd0; div = 8'd0;
    do_reset();
    auto_en = 1'b1;
    nd = 0;
    for (int k = 1; k <= 48; k++) begin
      exp_q.push_back({27'd0, ((k % 16) == 0), 4'((k - 1) % 16)});
      @(negedge clk);
      expv = exp_q.pop_front();
      if (sweep_done2) nd++;
      tests++;
      if ({sweep_done2, op_b2, op_a2} !== expv[4:0]) begin
        fails++;
        $display("[TB] FAIL auto_walk k=%0d: {done,b,a}=%b want %b", k,
                 {sweep_done2, op_b2, op_a2}, expv[4:0]);
      end
    end
    tests++;
    if (nd !== 3) begin
      fails++;
      $display("[TB] FAIL sweep_done_count: got %0d want 3", nd);
    end
  endtask

  task automatic test_div_period();
    auto_en = 1'b0;
    do_reset();
    auto_en = 1'b1; div = 8'd3;
    for (int k = 1; k <= 24; k++) begin
      exp_q.push_back(32'((k - 1) / 4));
      @(negedge clk);
      expv = exp_q.pop_front();
      tests++;
      if ({op_b, op_a} !== expv[7:0]) begin
        fails++;
        $display("[TB] FAIL div3 k=%0d: sweep view=%0d want %0d", k, {op_b, op_a}, expv[7:0]);
      end
    end
  endtask

  task automatic test_div_change();
    auto_en = 1'b0;
    do_reset();
    div = 8'd200; auto_en = 1'b1;
    repeat (10) @(negedge clk);
    div = 8'd3;
    repeat (2) @(negedge clk);
    tests++;
    if ({op_b, op_a} !== 8'd1) begin
      fails++;
      $display("[TB] FAIL div_shrink: sweep view=%0d want 1", {op_b, op_a});
    end
  endtask

  task automatic test_jk();
    auto_en = 1'b0; sel = 3'd7; a = 4'hF; b = 4'hF;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? 32'hF : 32'h0);
      pulse_step();
      expv = exp_q.pop_front();
      tests++;
      if (y !== expv[3:0]) begin
        fails++;
        $display("[TB] FAIL jk_toggle %0d: y=%b want %b", i, y, expv[3:0]);
      end
    end
    a = 4'hF; b = 4'h0;
    @(negedge clk);
    exp_q.push_back(32'hF);
    pulse_step();
    expv = exp_q.pop_front();
    tests++;
    if (y !== expv[3:0]) begin
      fails++;
      $display("[TB] FAIL jk_set: y=%b want %b", y, expv[3:0]);
    end
    a = 4'h0; b = 4'hF;
    @(negedge clk);
    exp_q.push_back(32'h0);
    pulse_step();
    expv = exp_q.pop_front();
    tests++;
    if (y !== expv[3:0]) begin
      fails++;
      $display("[TB] FAIL jk_clear: y=%b want %b", y, expv[3:0]);
    end
  endtask

  task automatic test_jk_retain();
    sel = 3'd7; a = 4'hF; b = 4'h0;
    @(negedge clk);
    pulse_step();
    tests++;
    if (y !== 4'hF) begin
      fails++;
      $display("[TB] FAIL retain_set: y=%b want 1111", y);
    end
    sel = 3'd0;
    repeat (2) @(negedge clk);
    tests++;
    if (y !== 4'h0) begin
      fails++;
      $display("[TB] FAIL retain_and: y=%b want 0000", y);
    end
    sel = 3'd7;
    @(negedge clk);
    tests++;
    if (y !== 4'hF) begin
      fails++;
      $display("[TB] FAIL retain_back: y=%b want 1111", y);
    end
  endtask

  task automatic test_reset_mid();
    auto_en = 1'b0; sel = 3'd0; div = 8'd0;
    do_reset();
    auto_en = 1'b1;
    repeat (9) @(negedge clk);
    tests++;
    if ({op_b, op_a} !== 8'd8) begin
      fails++;
      $display("[TB] FAIL mid_count: sweep view=%0d want 8", {op_b, op_a});
    end
    step = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({y, op_a, op_b, sweep_done, y2, op_a2, op_b2, sweep_done2} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got %h want 0",
               {y, op_a, op_b, sweep_done, y2, op_a2, op_b2, sweep_done2});
    end
    auto_en = 1'b0; sel = 3'd7; a = 4'hF; b = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (y !== 4'h0) begin
      fails++;
      $display("[TB] FAIL held_step: y=%b want 0000", y);
    end
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    tests++;
    if (y !== 4'hF) begin
      fails++;
      $display("[TB] FAIL rearmed_step: y=%b want 1111", y);
    end
    sel = 3'd0; auto_en = 1'b1; div = 8'd0;
    repeat (2) @(negedge clk);
    tests++;
    if ({op_b, op_a} !== 8'd1) begin
      fails++;
      $display("[TB] FAIL restart_sweep: sweep view=%0d want 1", {op_b, op_a});
    end
  endtask

  initial begin
    test_reset();
    test_gates();
    test_auto_walk();
    test_div_period();
    test_div_change();
    test_jk();
    test_jk_retain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
